// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV accelerator: image store, five layer banks,
// ready/busy start handshake and a host port for preload, readback and run control.
//
// state   | meaning
// S_IDLE  | no run yet; host port open
// S_START | ready asserted, waiting for CONV busy (bounded by START_TO)
// S_RUN   | CONV busy; image and layer ports live, run_cycles counting
// S_DONE  | run finished or timed out; done held, host port open
module conv_mem_responder #(
   parameter int DW        = 20,
   parameter int IMG_DEPTH = 4096,
   parameter int L1_DEPTH  = 1024,
   parameter int L2_DEPTH  = 2048,
   parameter int START_TO  = 1024
) (
   input  logic          clk,
   input  logic          reset,
   output logic          ready,
   input  logic          busy,
   input  logic [11:0]   iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [11:0]   caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [11:0]   caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   input  logic          host_we,
   input  logic          host_re,
   input  logic [2:0]    host_sel,
   input  logic [11:0]   host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   input  logic          host_start,
   output logic          done,
   output logic          timeout,
   output logic          addr_err,
   output logic [31:0]   run_cycles
);
   localparam int AW_IMG = $clog2(IMG_DEPTH);
   localparam int AW_L1  = $clog2(L1_DEPTH);
   localparam int AW_L2  = $clog2(L2_DEPTH);
   localparam int TW     = $clog2(START_TO);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            timeout_q, timeout_d;
   logic            addr_err_q, addr_err_d;
   logic [31:0]     run_cycles_q, run_cycles_d;
   logic [DW-1:0]   idata_q, idata_d;
   logic [DW-1:0]   cdata_rd_q, cdata_rd_d;
   logic [DW-1:0]   host_rdata_q, host_rdata_d;

   logic [DW-1:0]   img_mem [IMG_DEPTH];
   logic [DW-1:0]   l0_mem0 [IMG_DEPTH];
   logic [DW-1:0]   l0_mem1 [IMG_DEPTH];
   logic [DW-1:0]   l1_mem0 [L1_DEPTH];
   logic [DW-1:0]   l1_mem1 [L1_DEPTH];
   logic [DW-1:0]   l2_mem  [L2_DEPTH];

   logic            in_run, host_ok, host_blocked;
   logic            wr_en, wr_host, wr_valid;
   logic [2:0]      wr_sel;
   logic [11:0]     wr_addr;
   logic [DW-1:0]   wr_data;
   logic            rd_layer, rd_host, rd_valid;
   logic [2:0]      rd_sel;
   logic [11:0]     rd_addr, img_raddr;
   logic [DW-1:0]   img_rdata, bank_mux, bank_rdata;
   logic            err_set;

   // Select 0 addresses the image store and is only reachable from the host port.
   function automatic logic in_range(input logic [2:0] sel, input logic [11:0] addr,
                                     input logic from_host);
      case (sel)
         3'd0:       in_range = from_host && (32'(addr) < IMG_DEPTH);
         3'd1, 3'd2: in_range = 32'(addr) < IMG_DEPTH;
         3'd3, 3'd4: in_range = 32'(addr) < L1_DEPTH;
         3'd5:       in_range = 32'(addr) < L2_DEPTH;
         default:    in_range = 1'b0;
      endcase
   endfunction

   assign in_run       = (state_q == S_RUN);
   assign host_ok      = (state_q == S_IDLE) || (state_q == S_DONE);
   assign host_blocked = !host_ok && (host_we || host_re);

   // Layer and host ports never overlap in time, so each bank needs one write
   // and one read port.
   always_comb begin
      wr_en   = 1'b0;
      wr_host = 1'b0;
      wr_sel  = '0;
      wr_addr = '0;
      wr_data = '0;
      if (in_run && cwr) begin
         wr_en   = 1'b1;
         wr_sel  = csel;
         wr_addr = caddr_wr;
         wr_data = cdata_wr;
      end else if (host_ok && host_we) begin
         wr_en   = 1'b1;
         wr_host = 1'b1;
         wr_sel  = host_sel;
         wr_addr = host_addr;
         wr_data = host_wdata;
      end
   end

   assign wr_valid  = wr_en && in_range(wr_sel, wr_addr, wr_host);

   assign rd_layer  = in_run && crd;
   assign rd_host   = host_ok && host_re;
   assign rd_sel    = rd_layer ? csel : host_sel;
   assign rd_addr   = rd_layer ? caddr_rd : host_addr;
   assign rd_valid  = in_range(rd_sel, rd_addr, !rd_layer);
   assign img_raddr = in_run ? iaddr : rd_addr;
   assign img_rdata = img_mem[img_raddr[AW_IMG-1:0]];

   always_comb begin
      bank_mux = '0;
      case (rd_sel)
         3'd0:    bank_mux = img_rdata;
         3'd1:    bank_mux = l0_mem0[rd_addr[AW_IMG-1:0]];
         3'd2:    bank_mux = l0_mem1[rd_addr[AW_IMG-1:0]];
         3'd3:    bank_mux = l1_mem0[rd_addr[AW_L1-1:0]];
         3'd4:    bank_mux = l1_mem1[rd_addr[AW_L1-1:0]];
         3'd5:    bank_mux = l2_mem[rd_addr[AW_L2-1:0]];
         default: bank_mux = '0;
      endcase
      bank_rdata = rd_valid ? bank_mux : '0;
   end

   assign err_set = (wr_en && !wr_valid) || ((rd_layer || rd_host) && !rd_valid) ||
                    host_blocked;

   // Arrays are deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_valid) begin
         case (wr_sel)
            3'd0:    img_mem[wr_addr[AW_IMG-1:0]] <= wr_data;
            3'd1:    l0_mem0[wr_addr[AW_IMG-1:0]] <= wr_data;
            3'd2:    l0_mem1[wr_addr[AW_IMG-1:0]] <= wr_data;
            3'd3:    l1_mem0[wr_addr[AW_L1-1:0]]  <= wr_data;
            3'd4:    l1_mem1[wr_addr[AW_L1-1:0]]  <= wr_data;
            3'd5:    l2_mem[wr_addr[AW_L2-1:0]]   <= wr_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      timeout_d    = timeout_q;
      run_cycles_d = run_cycles_q;
      addr_err_d   = addr_err_q | err_set;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (host_start) begin
               state_d      = S_START;
               timer_d      = TW'(START_TO - 1);
               timeout_d    = 1'b0;
               run_cycles_d = '0;
               addr_err_d   = 1'b0;
            end
         end
         S_START: begin
            if (busy) begin
               state_d = S_RUN;
            end else if (timer_q == '0) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_RUN: begin
            run_cycles_d = run_cycles_q + 32'd1;
            if (!busy) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      ready_d    = (state_d == S_START);
      done_d     = (state_d == S_DONE);
      idata_d    = (in_run && busy) ? img_rdata : '0;
      cdata_rd_d = rd_layer ? bank_rdata : cdata_rd_q;
      if (host_blocked)  host_rdata_d = '0;
      else if (rd_host)  host_rdata_d = bank_rdata;
      else               host_rdata_d = host_rdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         addr_err_q   <= 1'b0;
         run_cycles_q <= '0;
         idata_q      <= '0;
         cdata_rd_q   <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         addr_err_q   <= addr_err_d;
         run_cycles_q <= run_cycles_d;
         idata_q      <= idata_d;
         cdata_rd_q   <= cdata_rd_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   assign ready      = ready_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign addr_err   = addr_err_q;
   assign run_cycles = run_cycles_q;
   assign idata      = idata_q;
   assign cdata_rd   = cdata_rd_q;
   assign host_rdata = host_rdata_q;

endmodule
